// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencing controller.
// The decode and hazard units import the same state encoding and status codes.
package multdiv_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 6;

  localparam int DEF_TIMEOUT     = 40;
  localparam int DEF_RSTATUS     = 30;
  localparam int DEF_EXC_MULT    = 4;
  localparam int DEF_EXC_DIV     = 5;
  localparam int DEF_EXC_TIMEOUT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    WB    = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// Bundle of pipeline request, mult/div unit and writeback signals.
// master = pipeline/unit/regfile side, slave = the controller.
interface multdiv_ctrl_if;
  import multdiv_ctrl_pkg::*;

  logic              req_valid;
  logic              req_is_div;
  logic [DATA_W-1:0] req_opA;
  logic [DATA_W-1:0] req_opB;
  logic [REG_W-1:0]  req_rd;
  logic              stall;
  logic              busy;
  logic [REG_W-1:0]  pend_rd;
  logic [DATA_W-1:0] md_opA;
  logic [DATA_W-1:0] md_opB;
  logic              md_ctrl_mult;
  logic              md_ctrl_div;
  logic [DATA_W-1:0] md_result;
  logic              md_exception;
  logic              md_resultRDY;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_grant;

  modport master (
    output req_valid, req_is_div, req_opA, req_opB, req_rd,
    output md_result, md_exception, md_resultRDY, wb_grant,
    input  stall, busy, pend_rd, md_opA, md_opB, md_ctrl_mult, md_ctrl_div,
    input  wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  req_valid, req_is_div, req_opA, req_opB, req_rd,
    input  md_result, md_exception, md_resultRDY, wb_grant,
    output stall, busy, pend_rd, md_opA, md_opB, md_ctrl_mult, md_ctrl_div,
    output wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/multdiv_ctrl_watchdog_counter.sv
// Watchdog for the BUSY phase: clear wins over enable, tc flags the last allowed cycle.
module watchdog_counter
  import multdiv_ctrl_pkg::*;
#(
  parameter int TC = DEF_TIMEOUT - 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt;

  // count enabled cycles since the last clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CNT_W'(TC));
endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between the pipeline and the shared multiply/divide unit:
// accept, one-cycle start pulse, wait for ready (or watchdog), handshaked writeback.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int RSTATUS     = DEF_RSTATUS,
  parameter int EXC_MULT    = DEF_EXC_MULT,
  parameter int EXC_DIV     = DEF_EXC_DIV,
  parameter int EXC_TIMEOUT = DEF_EXC_TIMEOUT
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_ctrl_if.slave bus
);
  state_t            state;
  logic              is_div;
  logic [REG_W-1:0]  pend_rd;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] md_opA, md_opB, wb_data;
  logic              md_ctrl_mult, md_ctrl_div, wb_valid;
  logic              wd_clr, wd_en, wd_tc;

  // watchdog restarts in START so a stale count never leaks into the next op;
  // tc fires in the TIMEOUT-th BUSY cycle
  assign wd_clr = (state == START);
  assign wd_en  = (state == BUSY);

  watchdog_counter #(.TC(TIMEOUT - 1)) u_wd (
    .clock (clock),
    .reset (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .tc    (wd_tc)
  );

  // control FSM with its datapath registers; start pulses default low every cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      is_div       <= 1'b0;
      pend_rd      <= '0;
      md_opA       <= '0;
      md_opB       <= '0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          is_div       <= bus.req_is_div;
          pend_rd      <= bus.req_rd;
          md_opA       <= bus.req_opA;
          md_opB       <= bus.req_opB;
          md_ctrl_mult <= ~bus.req_is_div;
          md_ctrl_div  <= bus.req_is_div;
          state        <= START;
        end
        // ready may still be high from the previous op here, so it is not looked at
        START: state <= BUSY;
        BUSY: begin
          if (bus.md_resultRDY) begin
            wb_valid <= 1'b1;
            state    <= WB;
            if (bus.md_exception) begin
              wb_rd   <= REG_W'(RSTATUS);
              wb_data <= is_div ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MULT);
            end else begin
              wb_rd   <= pend_rd;
              wb_data <= bus.md_result;
            end
          end else if (wd_tc) begin
            wb_valid <= 1'b1;
            wb_rd    <= REG_W'(RSTATUS);
            wb_data  <= DATA_W'(EXC_TIMEOUT);
            state    <= WB;
          end
        end
        WB: if (bus.wb_grant) begin
          wb_valid <= 1'b0;
          pend_rd  <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.stall        = bus.req_valid & (state != IDLE);
  assign bus.pend_rd      = pend_rd;
  assign bus.md_opA       = md_opA;
  assign bus.md_opB       = md_opB;
  assign bus.md_ctrl_mult = md_ctrl_mult;
  assign bus.md_ctrl_div  = md_ctrl_div;
  assign bus.wb_valid     = wb_valid;
  assign bus.wb_rd        = wb_rd;
  assign bus.wb_data      = wb_data;
endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller between the processor pipeline and the shared multiply/divide unit. Accepts one MULT or DIV request at a time, latches the operands and destination register, issues a single-cycle start pulse to the unit, waits for its result-ready flag, and returns the result through a handshaked writeback port. It also reports busy state and the pending destination to the hazard logic. On an arithmetic exception it redirects the write to the status register. A watchdog aborts operations that never complete.

## Interface
Parameters:
- TIMEOUT, 40: maximum cycles spent in BUSY before abort.
- RSTATUS, 30: register written on exception or abort.
- EXC_MULT, 4: status code for multiply overflow.
- EXC_DIV, 5: status code for divide by zero.
- EXC_TIMEOUT, 6: status code for watchdog abort.

Ports (one clock `clock`; reset `reset` is asynchronous, active-high):
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- req_valid  in  1  pipeline presents a MULT/DIV instruction.
- req_is_div  in  1  1 = divide, 0 = multiply.
- req_opA, req_opB  in  32  operands.
- req_rd  in  5  destination register.
- stall  out  1  `req_valid & (state != IDLE)`; combinational.
- busy  out  1  state != IDLE.
- pend_rd  out  5  latched destination; 0 when IDLE.
- md_opA, md_opB  out  32  operands to the unit; registered.
- md_ctrl_mult, md_ctrl_div  out  1  start pulses; registered, mutually exclusive.
- md_result  in  32  unit result.
- md_exception  in  1  unit exception flag.
- md_resultRDY  in  1  unit result-ready flag.
- wb_valid  out  1  writeback request.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback data.
- wb_grant  in  1  register-file port granted this cycle.

## Operation
- State machine: IDLE, START, BUSY, WB.
- IDLE: on `req_valid`, latch opA, opB, rd and is_div, then go to START. Otherwise stay.
- START (exactly 1 cycle):
  - Assert md_ctrl_mult or md_ctrl_div, selected by is_div.
  - md_resultRDY is ignored in this cycle, because it may be stale from the previous op.
  - Clear the watchdog counter and go to BUSY.
- BUSY:
  - Increment the watchdog each cycle.
  - On `md_resultRDY`, capture the result into the wb registers and go to WB:
    - md_exception = 0: wb_rd = rd, wb_data = md_result.
    - md_exception = 1: wb_rd = RSTATUS, wb_data = EXC_DIV if is_div, else EXC_MULT.
  - If the counter reaches TIMEOUT with no ready: wb_rd = RSTATUS, wb_data = EXC_TIMEOUT, go to WB.
  - If ready and timeout occur in the same cycle, ready wins.
- WB:
  - Hold wb_valid = 1 with rd/data stable until the cycle in which wb_grant = 1.
  - Then go to IDLE.
  - A request arriving during WB stalls and is accepted in the following IDLE cycle.
- Destination register 0: the op is executed normally. wb_valid is still raised, and the register file discards the write.
- md_opA/md_opB stay stable from START until the next accept.

## Timing
- Reset values: state IDLE; stall, busy, md_ctrl_*, wb_valid all 0; pend_rd, wb_rd, wb_data, md_opA, md_opB all 0.
- Accept at edge N (IDLE, req_valid).
  - Start pulse is high for cycle N+1 only.
  - Earliest ready is sampled at the edge ending cycle N+2.
  - wb_valid is high from the next cycle.
- Minimum occupancy is 4 cycles (IDLE→START→BUSY→WB→IDLE) with immediate grant.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The in-flight op is dropped with no writeback. The unit is re-armed by the next start pulse.
- wb_grant outside WB is ignored. md_resultRDY outside BUSY is ignored.

## Structure
- Shared package: the state enum (IDLE, START, BUSY, WB) and the default exception codes and RSTATUS, so the decode and hazard units use the same values.
- One natural sub-module, `watchdog_counter`: 6-bit, with clear, enable and terminal-count output.
- Everything else is one FSM plus its datapath registers.

## Test plan
- MULT 7×6, rd=3, ready after 10 BUSY cycles, grant immediate → one wb_valid cycle with rd=3, data=42; start pulse exactly 1 cycle; busy for 13 cycles.
- DIV 10/0 with md_exception=1 → wb_rd=30, wb_data=5. MULT overflow → wb_rd=30, wb_data=4.
- md_resultRDY held high from the previous op into START → ignored; completion occurs only on the BUSY-cycle ready.
- Unit never ready → after 40 BUSY cycles wb_rd=30, wb_data=6; ready and timeout in the same cycle → normal result.
- wb_grant withheld 3 cycles with req_valid high throughout → wb fields stable, stall=1 until grant; new request accepted in the IDLE cycle after grant.
- reset asserted mid-BUSY → all outputs 0 asynchronously, no writeback; next MULT 3×3 returns 9.
